// File: rtl/axis_sync_fifo_pkg.sv
// rtl/axis_sync_fifo_pkg.sv - sizing and entry-layout helpers for the AXI-Stream FIFO
// Purpose: functions shared by axis_sync_fifo and axis_fifo_ram; no ports.
package axis_sync_fifo_pkg;

   // Address width for a power-of-two word count; pointers carry one extra
   // bit on top of this to tell full from empty.
   function automatic int addr_width(input int depth_words);
      return $clog2(depth_words);
   endfunction

   // DEPTH is counted in bytes when tkeep is stored, otherwise in beats.
   function automatic int words_for(input int depth, input int keep_enable, input int keep_width);
      return (keep_enable != 0) ? depth / keep_width : depth;
   endfunction

   // Entry fields are packed LSB-first: data, keep, last, id, dest, user.
   // Each offset is the previous offset plus the previous field's width when
   // that field is stored; chaining it once more yields the entry width.
   function automatic int next_offset(input int offset, input int enable, input int width);
      return (enable != 0) ? offset + width : offset;
   endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// rtl/axis_fifo_ram.sv - simple dual-port RAM with a registered read port
// Ports: clk/rst; write port wr_en, wr_addr, wr_data; read port rd_en, rd_addr,
//        rd_data (registered, updated only when rd_en, cleared by rst).
module axis_fifo_ram
   import axis_sync_fifo_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [WIDTH-1:0] rd_data_q;
   logic [WIDTH-1:0] rd_data_d;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // The read register doubles as the FIFO output register, so it must hold
   // its value whenever no read is issued.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - single-clock AXI-Stream FIFO with optional frame mode
// Ports: clk, rst (sync, active-high); s_axis_* input stream; m_axis_* output
//        stream (registered); status_overflow / status_good_frame one-cycle
//        pulses, active only in frame mode.
module axis_sync_fifo
   import axis_sync_fifo_pkg::*;
#(
   parameter int DEPTH       = 4096,
   parameter int DATA_WIDTH  = 8,
   parameter int KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
   parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
   parameter int LAST_ENABLE = 1,
   parameter int ID_ENABLE   = 0,
   parameter int ID_WIDTH    = 8,
   parameter int DEST_ENABLE = 0,
   parameter int DEST_WIDTH  = 8,
   parameter int USER_ENABLE = 1,
   parameter int USER_WIDTH  = 1,
   parameter int FRAME_FIFO  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [ID_WIDTH-1:0]   s_axis_tid,
   input  logic [DEST_WIDTH-1:0] s_axis_tdest,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [ID_WIDTH-1:0]   m_axis_tid,
   output logic [DEST_WIDTH-1:0] m_axis_tdest,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   output logic                  status_overflow,
   output logic                  status_good_frame
);

   localparam int DEPTH_WORDS = words_for(DEPTH, KEEP_ENABLE, KEEP_WIDTH);
   localparam int ADDR_WIDTH  = addr_width(DEPTH_WORDS);
   localparam int KEEP_OFFSET = DATA_WIDTH;
   localparam int LAST_OFFSET = next_offset(KEEP_OFFSET, KEEP_ENABLE, KEEP_WIDTH);
   localparam int ID_OFFSET   = next_offset(LAST_OFFSET, LAST_ENABLE, 1);
   localparam int DEST_OFFSET = next_offset(ID_OFFSET, ID_ENABLE, ID_WIDTH);
   localparam int USER_OFFSET = next_offset(DEST_OFFSET, DEST_ENABLE, DEST_WIDTH);
   localparam int WIDTH       = next_offset(USER_OFFSET, USER_ENABLE, USER_WIDTH);

   // Pointer distance that means "every RAM word is occupied".
   localparam logic [ADDR_WIDTH:0] PTR_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0] commit_ptr_q, commit_ptr_d;
   logic                drop_q, drop_d;
   logic                ready_en_q, ready_en_d;
   logic                out_valid_q, out_valid_d;
   logic                overflow_q, overflow_d;
   logic                good_frame_q, good_frame_d;

   logic                full, empty, oversize;
   logic                wr_en, rd_en;
   logic [WIDTH-1:0]    wr_entry, rd_entry;
   logic                unused_inputs;

   assign unused_inputs = ^{s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tuser};

   assign wr_entry[DATA_WIDTH-1:0] = s_axis_tdata;
   assign m_axis_tdata             = rd_entry[DATA_WIDTH-1:0];

   if (KEEP_ENABLE != 0) begin : g_keep
      assign wr_entry[KEEP_OFFSET +: KEEP_WIDTH] = s_axis_tkeep;
      assign m_axis_tkeep = rd_entry[KEEP_OFFSET +: KEEP_WIDTH];
   end else begin : g_no_keep
      assign m_axis_tkeep = '1;
   end

   if (LAST_ENABLE != 0) begin : g_last
      assign wr_entry[LAST_OFFSET] = s_axis_tlast;
      assign m_axis_tlast = rd_entry[LAST_OFFSET];
   end else begin : g_no_last
      assign m_axis_tlast = 1'b1;
   end

   if (ID_ENABLE != 0) begin : g_id
      assign wr_entry[ID_OFFSET +: ID_WIDTH] = s_axis_tid;
      assign m_axis_tid = rd_entry[ID_OFFSET +: ID_WIDTH];
   end else begin : g_no_id
      assign m_axis_tid = '0;
   end

   if (DEST_ENABLE != 0) begin : g_dest
      assign wr_entry[DEST_OFFSET +: DEST_WIDTH] = s_axis_tdest;
      assign m_axis_tdest = rd_entry[DEST_OFFSET +: DEST_WIDTH];
   end else begin : g_no_dest
      assign m_axis_tdest = '0;
   end

   if (USER_ENABLE != 0) begin : g_user
      assign wr_entry[USER_OFFSET +: USER_WIDTH] = s_axis_tuser;
      assign m_axis_tuser = rd_entry[USER_OFFSET +: USER_WIDTH];
   end else begin : g_no_user
      assign m_axis_tuser = '0;
   end

   always_comb begin
      full     = (wr_ptr_q - rd_ptr_q) == PTR_FULL;
      empty    = commit_ptr_q == rd_ptr_q;
      // Current uncommitted frame alone fills the RAM: the reader can never
      // free space for it, so it has to be dropped rather than stalled.
      oversize = (wr_ptr_q - commit_ptr_q) == PTR_FULL;

      if (FRAME_FIFO != 0) begin
         s_axis_tready = ready_en_q && (!full || drop_q || oversize);
      end else begin
         s_axis_tready = ready_en_q && !full;
      end

      ready_en_d   = 1'b1;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      drop_d       = drop_q;
      wr_en        = 1'b0;
      overflow_d   = 1'b0;
      good_frame_d = 1'b0;

      if (s_axis_tvalid && s_axis_tready) begin
         if (FRAME_FIFO == 0) begin
            wr_en        = 1'b1;
            wr_ptr_d     = wr_ptr_q + 1'b1;
            commit_ptr_d = wr_ptr_d;
         end else if (drop_q || full) begin
            // Discard through tlast, then forget the partial frame.
            drop_d = 1'b1;
            if (s_axis_tlast) begin
               drop_d     = 1'b0;
               wr_ptr_d   = commit_ptr_q;
               overflow_d = 1'b1;
            end
         end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (s_axis_tlast) begin
               commit_ptr_d = wr_ptr_d;
               good_frame_d = 1'b1;
            end
         end
      end

      // Refill the output register whenever it is empty or being consumed.
      rd_en    = (!out_valid_q || m_axis_tready) && !empty;
      rd_ptr_d = rd_ptr_q;
      if (rd_en) begin
         rd_ptr_d    = rd_ptr_q + 1'b1;
         out_valid_d = 1'b1;
      end else if (m_axis_tready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         commit_ptr_q <= '0;
         drop_q       <= 1'b0;
         ready_en_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         overflow_q   <= 1'b0;
         good_frame_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         drop_q       <= drop_d;
         ready_en_q   <= ready_en_d;
         out_valid_q  <= out_valid_d;
         overflow_q   <= overflow_d;
         good_frame_q <= good_frame_d;
      end
   end

   assign m_axis_tvalid     = out_valid_q;
   assign status_overflow   = overflow_q;
   assign status_good_frame = good_frame_q;

   axis_fifo_ram #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wr_data (wr_entry),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rd_data (rd_entry)
   );

endmodule

// File: tb/tb_axis_sync_fifo.sv
// tb/tb_axis_sync_fifo.sv - self-checking bench for axis_sync_fifo
module tb_axis_sync_fifo;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   localparam int NFRAMES = 8000;

   // Wide instance: 512-bit beats, 1024 words.
   logic [511:0] b_s_tdata, b_m_tdata;
   logic [63:0]  b_s_tkeep, b_m_tkeep;
   logic         b_s_tvalid, b_s_tready, b_s_tlast, b_s_tuser;
   logic [7:0]   b_s_tid, b_s_tdest, b_m_tid, b_m_tdest;
   logic         b_m_tvalid, b_m_tready, b_m_tlast, b_m_tuser, b_ovf, b_good;

   // Small instance: 8-bit beats, 16 words, tid stored, tdest/tuser/tkeep not.
   logic [7:0] s_s_tdata, s_m_tdata, s_s_tdest, s_m_tdest;
   logic       s_s_tkeep, s_m_tkeep, s_s_tuser, s_m_tuser;
   logic [3:0] s_s_tid, s_m_tid;
   logic       s_s_tvalid, s_s_tready, s_s_tlast;
   logic       s_m_tvalid, s_m_tready, s_m_tlast, s_ovf, s_good;

   // Frame-mode instance: 8-bit beats, 16 words.
   logic [7:0] f_s_tdata, f_m_tdata, f_s_tid, f_m_tid, f_s_tdest, f_m_tdest;
   logic       f_s_tkeep, f_m_tkeep, f_s_tuser, f_m_tuser;
   logic       f_s_tvalid, f_s_tready, f_s_tlast;
   logic       f_m_tvalid, f_m_tready, f_m_tlast, f_ovf, f_good;

   axis_sync_fifo #(.DEPTH(1024*64), .DATA_WIDTH(512)) u_big (
      .clk(clk), .rst(rst),
      .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep), .s_axis_tvalid(b_s_tvalid),
      .s_axis_tready(b_s_tready), .s_axis_tlast(b_s_tlast), .s_axis_tid(b_s_tid),
      .s_axis_tdest(b_s_tdest), .s_axis_tuser(b_s_tuser),
      .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
      .m_axis_tready(b_m_tready), .m_axis_tlast(b_m_tlast), .m_axis_tid(b_m_tid),
      .m_axis_tdest(b_m_tdest), .m_axis_tuser(b_m_tuser),
      .status_overflow(b_ovf), .status_good_frame(b_good));

   axis_sync_fifo #(.DEPTH(16), .DATA_WIDTH(8), .ID_ENABLE(1), .ID_WIDTH(4),
                    .USER_ENABLE(0)) u_small (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_s_tdata), .s_axis_tkeep(s_s_tkeep), .s_axis_tvalid(s_s_tvalid),
      .s_axis_tready(s_s_tready), .s_axis_tlast(s_s_tlast), .s_axis_tid(s_s_tid),
      .s_axis_tdest(s_s_tdest), .s_axis_tuser(s_s_tuser),
      .m_axis_tdata(s_m_tdata), .m_axis_tkeep(s_m_tkeep), .m_axis_tvalid(s_m_tvalid),
      .m_axis_tready(s_m_tready), .m_axis_tlast(s_m_tlast), .m_axis_tid(s_m_tid),
      .m_axis_tdest(s_m_tdest), .m_axis_tuser(s_m_tuser),
      .status_overflow(s_ovf), .status_good_frame(s_good));

   axis_sync_fifo #(.DEPTH(16), .DATA_WIDTH(8), .FRAME_FIFO(1)) u_frame (
      .clk(clk), .rst(rst),
      .s_axis_tdata(f_s_tdata), .s_axis_tkeep(f_s_tkeep), .s_axis_tvalid(f_s_tvalid),
      .s_axis_tready(f_s_tready), .s_axis_tlast(f_s_tlast), .s_axis_tid(f_s_tid),
      .s_axis_tdest(f_s_tdest), .s_axis_tuser(f_s_tuser),
      .m_axis_tdata(f_m_tdata), .m_axis_tkeep(f_m_tkeep), .m_axis_tvalid(f_m_tvalid),
      .m_axis_tready(f_m_tready), .m_axis_tlast(f_m_tlast), .m_axis_tid(f_m_tid),
      .m_axis_tdest(f_m_tdest), .m_axis_tuser(f_m_tuser),
      .status_overflow(f_ovf), .status_good_frame(f_good));

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic [3:0] id;
   } beat_t;

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({b_m_tvalid, s_m_tvalid, f_m_tvalid} !== 3'b000) $display("FAIL rst_tvalid: got %b required 000", {b_m_tvalid, s_m_tvalid, f_m_tvalid});
      else passed++;
      total++;
      if ({b_s_tready, s_s_tready, f_s_tready} !== 3'b000) $display("FAIL rst_tready: got %b required 000", {b_s_tready, s_s_tready, f_s_tready});
      else passed++;
      total++;
      if ({f_ovf, f_good, s_ovf, s_good} !== 4'b0000) $display("FAIL rst_status: got %b required 0000", {f_ovf, f_good, s_ovf, s_good});
      else passed++;
      rst = 1'b0;
      #1;
      total++;
      if (s_s_tready !== 1'b0) $display("FAIL rst_ready_early: got %b required 0", s_s_tready);
      else passed++;
      @(negedge clk);
      total++;
      if ({b_s_tready, s_s_tready, f_s_tready} !== 3'b111) $display("FAIL rst_ready_after: got %b required 111", {b_s_tready, s_s_tready, f_s_tready});
      else passed++;
   endtask

   task automatic test_passthrough();
      logic [511:0] pt_data [128];
      logic         pt_user [128];
      int k;
      for (int i = 0; i < 128; i++) begin
         for (int w = 0; w < 16; w++) pt_data[i][w*32 +: 32] = $urandom;
         pt_data[i][31:0] = 32'(i % 32 + i / 32);
         pt_user[i] = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      b_m_tready = 1'b1;
      for (int c = 0; c < 131; c++) begin
         if (c < 128) begin
            b_s_tvalid = 1'b1;
            b_s_tdata  = pt_data[c];
            b_s_tkeep  = '1;
            b_s_tlast  = (c % 32 == 31);
            b_s_tuser  = pt_user[c];
         end else begin
            b_s_tvalid = 1'b0;
         end
         @(negedge clk);
         if (c < 128) begin
            total++;
            if (b_s_tready !== 1'b1) $display("FAIL pt_ready: beat %0d got %b required 1", c, b_s_tready);
            else passed++;
         end
         k = c - 2;
         total++;
         if (b_m_tvalid !== (k >= 0 && k < 128)) $display("FAIL pt_valid: cycle %0d got %b required %b", c, b_m_tvalid, (k >= 0 && k < 128));
         else passed++;
         if (k >= 0 && k < 128) begin
            total++;
            if ({b_m_tdata, b_m_tkeep, b_m_tlast, b_m_tuser, b_m_tid, b_m_tdest} !==
                {pt_data[k], {64{1'b1}}, (k % 32 == 31), pt_user[k], 8'h00, 8'h00})
               $display("FAIL pt_beat: beat %0d got %h/%b/%b required %h/%b/%b", k, b_m_tdata[31:0], b_m_tlast, b_m_tuser, pt_data[k][31:0], (k % 32 == 31), pt_user[k]);
            else passed++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_fill_drain();
      int accepted = 0;
      s_m_tready = 1'b0;
      s_s_tvalid = 1'b1;
      for (int c = 0; c < 25; c++) begin
         s_s_tdata = 8'(accepted);
         s_s_tid   = 4'(accepted);
         s_s_tlast = (accepted % 4 == 3);
         @(negedge clk);
         if (s_s_tvalid && s_s_tready) accepted++;
         @(posedge clk); #1;
      end
      s_s_tvalid = 1'b0;
      total++;
      if (accepted != 17) $display("FAIL fill_count: got %0d required 17", accepted);
      else passed++;
      s_m_tready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         total++;
         if ({s_m_tvalid, s_m_tdata, s_m_tkeep, s_m_tlast, s_m_tid, s_m_tdest, s_m_tuser} !==
             {1'b1, 8'(i), 1'b1, (i % 4 == 3), 4'(i), 8'h00, 1'b0})
            $display("FAIL drain_beat: %0d got v=%b d=%h l=%b id=%h required v=1 d=%h l=%b id=%h", i, s_m_tvalid, s_m_tdata, s_m_tlast, s_m_tid, 8'(i), (i % 4 == 3), 4'(i));
         else passed++;
         if (i == 0) begin
            total++;
            if (s_s_tready !== 1'b0) $display("FAIL fill_still_full: got %b required 0", s_s_tready);
            else passed++;
         end
         if (i == 1) begin
            total++;
            if (s_s_tready !== 1'b1) $display("FAIL fill_ready_back: got %b required 1", s_s_tready);
            else passed++;
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      total++;
      if (s_m_tvalid !== 1'b0) $display("FAIL drain_empty: got %b required 0", s_m_tvalid);
      else passed++;
   endtask

   task automatic test_frame_mode();
      int good = 0, ovf = 0;
      @(posedge clk); #1;
      f_m_tready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         f_s_tvalid = (c < 4);
         f_s_tdata  = 8'(8'hA0 + c);
         f_s_tlast  = (c == 3);
         @(negedge clk);
         good += int'(f_good);
         ovf  += int'(f_ovf);
         if (c < 4) begin
            total++;
            if (f_s_tready !== 1'b1) $display("FAIL frm_ready: beat %0d got %b required 1", c, f_s_tready);
            else passed++;
         end
         total++;
         if (f_m_tvalid !== (c >= 5 && c <= 8)) $display("FAIL frm_valid: cycle %0d got %b required %b", c, f_m_tvalid, (c >= 5 && c <= 8));
         else passed++;
         if (c >= 5 && c <= 8) begin
            total++;
            if ({f_m_tdata, f_m_tlast} !== {8'(8'hA0 + c - 5), (c == 8)})
               $display("FAIL frm_beat: cycle %0d got %h/%b required %h/%b", c, f_m_tdata, f_m_tlast, 8'(8'hA0 + c - 5), (c == 8));
            else passed++;
         end
         @(posedge clk); #1;
      end
      total++;
      if (good != 1 || ovf != 0) $display("FAIL frm_status: got good=%0d ovf=%0d required good=1 ovf=0", good, ovf);
      else passed++;
   endtask

   task automatic test_oversize();
      logic [7:0] seen_data [$];
      logic       seen_last [$];
      logic [7:0] exp_data [2];
      int good = 0, ovf = 0;
      exp_data[0] = 8'hC0;
      exp_data[1] = 8'hC1;
      f_m_tready = 1'b1;
      for (int c = 0; c < 32; c++) begin
         f_s_tvalid = (c < 22);
         f_s_tdata  = (c < 20) ? 8'(8'h10 + c) : 8'(8'hC0 + c - 20);
         f_s_tlast  = (c == 19) || (c == 21);
         @(negedge clk);
         good += int'(f_good);
         ovf  += int'(f_ovf);
         if (c < 22) begin
            total++;
            if (f_s_tready !== 1'b1) $display("FAIL ovs_ready: beat %0d got %b required 1", c, f_s_tready);
            else passed++;
         end
         if (f_m_tvalid) begin
            seen_data.push_back(f_m_tdata);
            seen_last.push_back(f_m_tlast);
         end
         @(posedge clk); #1;
      end
      f_s_tvalid = 1'b0;
      total++;
      if (ovf != 1 || good != 1) $display("FAIL ovs_status: got ovf=%0d good=%0d required ovf=1 good=1", ovf, good);
      else passed++;
      total++;
      if (seen_data.size() != 2) $display("FAIL ovs_count: got %0d beats required 2", seen_data.size());
      else passed++;
      for (int i = 0; i < seen_data.size() && i < 2; i++) begin
         total++;
         if ({seen_data[i], seen_last[i]} !== {exp_data[i], (i == 1)})
            $display("FAIL ovs_beat: %0d got %h/%b required %h/%b", i, seen_data[i], seen_last[i], exp_data[i], (i == 1));
         else passed++;
      end
   endtask

   task automatic test_random();
      beat_t q [$];
      beat_t cur, head;
      int frames_done = 0, beat_idx = 0, frame_len = 1;
      bit took = 1'b0, finished = 1'b0;
      cur = '0;
      s_s_tvalid = 1'b0;
      for (int cyc = 0; cyc < 60000 && !finished; cyc++) begin
         if (took) s_s_tvalid = 1'b0;
         if (!s_s_tvalid && frames_done < NFRAMES && $urandom_range(0, 99) < 78) begin
            if (beat_idx == 0) frame_len = $urandom_range(1, 3);
            cur.data = 8'($urandom);
            cur.id   = 4'(frames_done);
            cur.last = (beat_idx == frame_len - 1);
            s_s_tdata  = cur.data;
            s_s_tid    = cur.id;
            s_s_tlast  = cur.last;
            s_s_tvalid = 1'b1;
         end
         s_m_tready = 1'($urandom_range(0, 1));
         @(negedge clk);
         // Output is compared against the model head every valid cycle, so a
         // stalled beat that changes is caught as well as loss or reordering.
         if (s_m_tvalid) begin
            total++;
            if (q.size() == 0) begin
               $display("FAIL rand_extra: got beat %h with nothing outstanding", s_m_tdata);
            end else begin
               head = q[0];
               if ({s_m_tdata, s_m_tlast, s_m_tid, s_m_tkeep, s_m_tdest} !== {head.data, head.last, head.id, 1'b1, 8'h00})
                  $display("FAIL rand_beat: got %h/%b/%h required %h/%b/%h", s_m_tdata, s_m_tlast, s_m_tid, head.data, head.last, head.id);
               else passed++;
               if (s_m_tready) head = q.pop_front();
            end
         end
         took = s_s_tvalid && s_s_tready;
         if (took) begin
            q.push_back(cur);
            if (cur.last) begin
               frames_done++;
               beat_idx = 0;
            end else begin
               beat_idx++;
            end
         end
         finished = (frames_done == NFRAMES) && (q.size() == 0);
         @(posedge clk); #1;
      end
      s_s_tvalid = 1'b0;
      total++;
      if (!finished) $display("FAIL rand_timeout: got frames=%0d pending=%0d required frames=%0d pending=0", frames_done, q.size(), NFRAMES);
      else passed++;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (s_m_tvalid !== 1'b0) $display("FAIL rand_idle: got %b required 0", s_m_tvalid);
      else passed++;
   endtask

   initial begin
      b_s_tdata = '0; b_s_tkeep = '0; b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
      b_s_tid = '0; b_s_tdest = '0; b_s_tuser = 1'b0; b_m_tready = 1'b0;
      s_s_tdata = '0; s_s_tkeep = 1'b0; s_s_tvalid = 1'b0; s_s_tlast = 1'b0;
      s_s_tid = '0; s_s_tdest = '0; s_s_tuser = 1'b0; s_m_tready = 1'b0;
      f_s_tdata = '0; f_s_tkeep = 1'b0; f_s_tvalid = 1'b0; f_s_tlast = 1'b0;
      f_s_tid = '0; f_s_tdest = '0; f_s_tuser = 1'b0; f_m_tready = 1'b0;
      test_reset();
      test_passthrough();
      test_fill_drain();
      test_frame_mode();
      test_oversize();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/axis_sync_fifo.md
Name: axis_sync_fifo

Overview:
Single-clock AXI4-Stream FIFO for packet buffering. In the design it sits between the wire-side packet source and the packet-processing core's RX input, with 1024 x 512-bit entries. It has optional sideband fields (keep/last/id/dest/user) and an optional store-and-forward frame mode. The output is registered, and the FIFO sustains full throughput of one beat per cycle.

Parameters:
DEPTH, 4096, capacity in bytes when KEEP_ENABLE=1, else in beats; DEPTH_WORDS = DEPTH/KEEP_WIDTH (or DEPTH), must be a power of two >= 2
DATA_WIDTH, 8, tdata width in bits
KEEP_ENABLE, (DATA_WIDTH>8), 1 = store tkeep
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
LAST_ENABLE, 1, 1 = store tlast
ID_ENABLE, 0, 1 = store tid
ID_WIDTH, 8, tid width
DEST_ENABLE, 0, 1 = store tdest
DEST_WIDTH, 8, tdest width
USER_ENABLE, 1, 1 = store tuser
USER_WIDTH, 1, tuser width
FRAME_FIFO, 0, 1 = store-and-forward; output a frame only once its tlast beat is stored

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  DATA_WIDTH  input data
s_axis_tkeep  in  KEEP_WIDTH  input byte enables
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input end of frame
s_axis_tid  in  ID_WIDTH  input id
s_axis_tdest  in  DEST_WIDTH  input destination
s_axis_tuser  in  USER_WIDTH  input user
m_axis_tdata/tkeep/tvalid/tlast/tid/tdest/tuser  out  matching widths  output stream
m_axis_tready  in  1  output ready
status_overflow  out  1  one-cycle pulse: frame dropped for oversize (FRAME_FIFO only)
status_good_frame  out  1  one-cycle pulse: frame committed

Behaviour:
- One clock domain (clk). Reset (rst) is synchronous and active-high. Reset clears the write, read and commit pointers and the output register; m_axis_tvalid=0 and status pulses are 0. s_axis_tready=0 while rst=1 and becomes 1 the cycle after rst falls. Reset mid-frame discards all contents.
- Storage: RAM of DEPTH_WORDS entries. Each entry is the concatenation of the enabled fields. Pointers are ADDR_WIDTH+1 bits (ADDR_WIDTH = log2 DEPTH_WORDS); the extra MSB separates full from empty.
  - full = (wr_ptr - rd_ptr) == DEPTH_WORDS
  - empty = (commit_ptr == rd_ptr)
- Write: a beat is accepted when s_axis_tvalid && s_axis_tready.
  - FRAME_FIFO=0: s_axis_tready = !full; commit_ptr tracks wr_ptr every beat.
- Read: the output register is loaded from RAM when (!m_axis_tvalid || m_axis_tready) && !empty. m_axis_tvalid holds until the handshake. Output fields must not change while tvalid && !tready.
- Latency: a beat accepted at edge k, into an empty FIFO, is valid on m_axis after edge k+1. A continuous stream with tready=1 passes one beat per cycle with no bubbles.
- Capacity: with m_axis_tready=0, the FIFO accepts exactly DEPTH_WORDS+1 beats (RAM plus output register) before tready drops.
- Disabled fields:
  - tkeep out = all ones when KEEP_ENABLE=0.
  - tlast out = 1 when LAST_ENABLE=0.
  - tid/tdest/tuser out = 0 when their enable is 0.
- Simultaneous read and write when full: tready stays low that cycle. The freed slot is visible the next cycle.
- FRAME_FIFO=1:
  - Beats are written at wr_ptr. commit_ptr advances to wr_ptr+1 on the tlast beat, and status_good_frame pulses that cycle.
  - The reader sees only committed beats.
  - If a frame would exceed free space: enter drop state, keep s_axis_tready=1, discard beats through tlast, rewind wr_ptr to commit_ptr, and pulse status_overflow on the tlast beat.
  - Outside drop state, s_axis_tready = !full.
- FRAME_FIFO=0: status pulses are held at 0.

Decomposition:
- Shared package holds:
  - the clog2-based ADDR_WIDTH function
  - field offset constants for the packed entry (KEEP_OFFSET, LAST_OFFSET, ID_OFFSET, DEST_OFFSET, USER_OFFSET, WIDTH)
- One natural sub-module: axis_fifo_ram, a simple dual-port RAM (one write port, one registered read port) instantiated once.

Test Plan:
1. Reset: rst=1 for 3 cycles -> m_axis_tvalid=0, s_axis_tready=0. One cycle after release -> s_axis_tready=1.
2. Passthrough: DATA_WIDTH=512, DEPTH=1024*64, m_tready=1, 32-beat frames with tdata = beat index + frame counter and tkeep all ones -> identical beat sequence out, tlast on beat 31, one beat per cycle, first beat out one cycle after acceptance.
3. Fill and drain: DEPTH_WORDS=16, m_tready=0 -> exactly 17 beats accepted, then tready=0. Release m_tready -> 17 beats out in order. tready re-asserts the cycle after the first read.
4. Random backpressure: 78% s_tvalid and 50% m_tready -> no loss, duplication or reorder over 8000 frames; outputs stable while stalled.
5. Frame mode: FRAME_FIFO=1, 4-beat frame with m_tready=1 -> no m_tvalid until the cycle after the tlast beat is stored; status_good_frame pulses once.
6. Oversize: FRAME_FIFO=1, DEPTH_WORDS=16, 20-beat frame, then a 2-beat frame -> all 20 beats accepted with tready=1, status_overflow pulses once, only the 2-beat frame appears on output.
